crossing_scheduler: RTL and testbench

//  Phase sequencer for a main-road signal shared by N_XWALK pedestrian crosswalks.

---
 rtl/crossing_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/crossing_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_crossing_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : crossing_pkg
//  Purpose : Shared phase encoding and default timing for crossing_scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
package crossing_pkg;

    typedef enum logic [2:0] {
        GREEN   = 3'd0,
        YELLOW  = 3'd1,
        ALL_RED = 3'd2,
        WALK    = 3'd3,
        FLASH   = 3'd4,
        CLEAR   = 3'd5
    } phase_e;

    localparam int DEF_N_XWALK     = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_T_MIN_GREEN = 1000;
    localparam int DEF_T_YELLOW    = 200;
    localparam int DEF_T_ALLRED    = 100;
    localparam int DEF_T_WALK      = 1200;
    localparam int DEF_T_FLASH     = 600;
    localparam int DEF_T_BLINK     = 100;

    // True when a duration is non-zero and representable in a w-bit counter.
    function automatic bit t_fits(input int t, input int w);
        return (t >= 1) && (longint'(t) < (longint'(1) << w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Purpose : Combinational round-robin pick of the first pending bit at or
//            above rr_ptr, wrapping modulo N.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         pending,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IDX_W = $clog2(N);

    int scan_idx;

    // Walk offsets from farthest to nearest so the nearest hit is kept last.
    always_comb begin
        grant_idx   = '0;
        grant_valid = |pending;
        scan_idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (pending[IDX_W'(scan_idx)]) begin
                grant_idx = IDX_W'(scan_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : crossing_scheduler
//  Purpose : Main-road phase sequencer serving N_XWALK pedestrian crosswalks
//            round-robin after a minimum green; one clock = one 10 ms tick.
//  Rev     : 1.0  initial release
// ============================================================================
module crossing_scheduler
    import crossing_pkg::*;
#(
    parameter int N_XWALK     = DEF_N_XWALK,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_WALK      = DEF_T_WALK,
    parameter int T_FLASH     = DEF_T_FLASH,
    parameter int T_BLINK     = DEF_T_BLINK
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_XWALK-1:0]         btn,
    output logic                       green,
    output logic                       yellow,
    output logic                       red,
    output logic [N_XWALK-1:0]         walk,
    output logic [N_XWALK-1:0]         no_walk,
    output logic                       beeper,
    output logic                       busy,
    output logic [$clog2(N_XWALK)-1:0] served_idx
);

    localparam int IDX_W = $clog2(N_XWALK);

    if (N_XWALK < 2 || N_XWALK > 8) begin : g_bad_n_xwalk
        $error("crossing_scheduler: N_XWALK must be within 2..8");
    end

    if (!t_fits(T_MIN_GREEN, CNT_W) || !t_fits(T_YELLOW, CNT_W) ||
        !t_fits(T_ALLRED, CNT_W)    || !t_fits(T_WALK, CNT_W)   ||
        !t_fits(T_FLASH, CNT_W)     || !t_fits(T_BLINK, CNT_W)) begin : g_bad_cnt_w
        $error("crossing_scheduler: every T_* must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MIN_GREEN   = CNT_W'(T_MIN_GREEN);
    localparam logic [CNT_W-1:0] LAST_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LAST_WALK   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LAST_FLASH  = CNT_W'(T_FLASH - 1);
    localparam logic [CNT_W-1:0] LAST_BLINK  = CNT_W'(T_BLINK - 1);
    localparam logic [N_XWALK-1:0] ONE_HOT0  = {{(N_XWALK-1){1'b0}}, 1'b1};

    phase_e             state;
    phase_e             state_next;
    logic [N_XWALK-1:0] btn_meta;
    logic [N_XWALK-1:0] btn_sync;
    logic [N_XWALK-1:0] pending;
    logic [N_XWALK-1:0] set_mask;
    logic [N_XWALK-1:0] served_mask;
    logic [N_XWALK-1:0] grant_mask;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   green_tmr;
    logic [CNT_W-1:0]   blink_cnt;
    logic               blink_off;
    logic               phase_exit;
    logic               grant_take;

    rr_arbiter #(
        .N (N_XWALK)
    ) u_arb (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign phase_exit  = (state_next != state);
    assign grant_take  = (state == GREEN) && phase_exit;
    assign served_mask = ONE_HOT0 << served_idx;
    assign grant_mask  = ONE_HOT0 << grant_idx;
    assign rr_next     = (grant_idx == IDX_W'(N_XWALK - 1)) ? '0 : grant_idx + IDX_W'(1);
    // A press on the crosswalk currently walking is dropped, not queued.
    assign set_mask    = btn_sync & ~((state == WALK) ? served_mask : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= GREEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GREEN:   if (grant_valid && green_tmr == MIN_GREEN) state_next = YELLOW;
            YELLOW:  if (phase_cnt == LAST_YELLOW)              state_next = ALL_RED;
            ALL_RED: if (phase_cnt == LAST_ALLRED)              state_next = WALK;
            WALK:    if (phase_cnt == LAST_WALK)                state_next = FLASH;
            FLASH:   if (phase_cnt == LAST_FLASH)               state_next = CLEAR;
            CLEAR:   if (phase_cnt == LAST_ALLRED)              state_next = GREEN;
            default:                                            state_next = GREEN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            green_tmr <= MIN_GREEN;
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            if (phase_exit) begin
                phase_cnt <= '0;
            end else if (state != GREEN) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end

            if (state == CLEAR && phase_exit) begin
                green_tmr <= '0;
            end else if (state == GREEN && green_tmr != MIN_GREEN) begin
                green_tmr <= green_tmr + CNT_W'(1);
            end

            if (state != FLASH) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_cnt == LAST_BLINK) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // Grant clear is applied after the set so a coincident press is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            served_idx <= '0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
            pending  <= (pending | set_mask) & ~(grant_take ? grant_mask : '0);
            if (grant_take) begin
                served_idx <= grant_idx;
                rr_ptr     <= rr_next;
            end
        end
    end

    always_comb begin
        green   = 1'b0;
        yellow  = 1'b0;
        red     = 1'b0;
        walk    = '0;
        no_walk = '1;
        case (state)
            GREEN:   green  = 1'b1;
            YELLOW:  yellow = 1'b1;
            default: red    = 1'b1;
        endcase
        if (state == WALK) begin
            walk    = served_mask;
            no_walk = ~served_mask;
        end else if (state == FLASH && blink_off) begin
            no_walk = ~served_mask;
        end
        beeper = |walk;
        busy   = (state != GREEN);
    end

endmodule
`default_nettype wire

// File: tb/tb_crossing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_crossing_scheduler
//  Purpose : Directed self-checking bench for crossing_scheduler (N_XWALK=2).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_crossing_scheduler;

    localparam int N     = 2;
    localparam int IDX_W = 1;
    localparam int OW    = 5 + 2 * N + IDX_W;

    localparam int PH_G  = 0;
    localparam int PH_Y  = 1;
    localparam int PH_AR = 2;
    localparam int PH_W  = 3;
    localparam int PH_F  = 4;
    localparam int PH_C  = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     btn   = '0;
    logic             green, yellow, red, beeper, busy;
    logic [N-1:0]     walk, no_walk;
    logic [IDX_W-1:0] served_idx;
    logic [OW-1:0]    obs;

    int vectors     = 0;
    int miscompares = 0;
    int last_idx    = 0;
    int sb[$];

    crossing_scheduler #(
        .N_XWALK (N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn        (btn),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .walk       (walk),
        .no_walk    (no_walk),
        .beeper     (beeper),
        .busy       (busy),
        .served_idx (served_idx)
    );

    always #5 clock = ~clock;

    assign obs = {green, yellow, red, beeper, busy, walk, no_walk, served_idx};

    function automatic logic [OW-1:0] exp_out(input int ph, input int idx, input int k);
        logic [N-1:0] m;
        logic [N-1:0] w;
        logic [N-1:0] nw;
        logic g, y, r;
        m  = N'(1) << idx;
        w  = '0;
        nw = '1;
        g  = (ph == PH_G);
        y  = (ph == PH_Y);
        r  = !g && !y;
        if (ph == PH_W) begin
            w  = m;
            nw = ~m;
        end
        if (ph == PH_F && ((k / 100) % 2) != 0) begin
            nw = ~m;
        end
        return {g, y, r, |w, ph != PH_G, w, nw, IDX_W'(idx)};
    endfunction

    task automatic check_phase(input string tag, input int ph, input int idx, input int k0,
                               input int n, input logic [N-1:0] drv, input int drv_on,
                               input int drv_off);
        bit            bad   = 1'b0;
        int            bad_k = 0;
        logic [OW-1:0] got   = '0;
        logic [OW-1:0] want  = '0;
        for (int k = k0; k < n; k++) begin
            @(negedge clock);
            if (!bad && obs !== exp_out(ph, idx, k)) begin
                bad   = 1'b1;
                bad_k = k;
                got   = obs;
                want  = exp_out(ph, idx, k);
            end
            if (k == drv_on)  btn = drv;
            if (k == drv_off) btn = '0;
        end
        vectors++;
        assert (!bad) else begin
            miscompares++;
            $error("FAIL %s at k=%0d: observed %h expected %h", tag, bad_k, got, want);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        last_idx = 0;
        check_phase("reset", PH_G, 0, 0, 3, '0, -1, -1);
        reset = 1'b0;
    endtask

    // One full service: green wait, then the five timed phases.
    task automatic service(input string tag, input int exp_wait,
                           input logic [N-1:0] walk_btn, input logic [N-1:0] flash_btn);
        int            idx  = 0;
        int            n    = 0;
        bit            seen = 1'b0;
        bit            bad  = 1'b0;
        logic [OW-1:0] got  = '0;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL %s/scoreboard: observed empty queue expected one entry", tag);
        end
        if (sb.size() != 0) idx = sb.pop_front();
        while (!seen && n < exp_wait + 20) begin
            @(negedge clock);
            n++;
            if (yellow === 1'b1) begin
                seen = 1'b1;
            end else if (!bad && obs !== exp_out(PH_G, last_idx, 0)) begin
                bad = 1'b1;
                got = obs;
            end
            btn = '0;
        end
        vectors++;
        assert (seen && n == exp_wait && !bad) else begin
            miscompares++;
            $error("FAIL %s/green: observed %0d cycles to yellow (seen=%0d lamp_err=%0d %h) expected %0d",
                   tag, n, seen, bad, got, exp_wait);
        end
        vectors++;
        assert (obs === exp_out(PH_Y, idx, 0)) else begin
            miscompares++;
            $error("FAIL %s/grant: observed %h expected %h", tag, obs, exp_out(PH_Y, idx, 0));
        end
        check_phase({tag, "/yellow"}, PH_Y,  idx, 1, 200,  '0,        -1,  -1);
        check_phase({tag, "/allred"}, PH_AR, idx, 0, 100,  '0,        -1,  -1);
        check_phase({tag, "/walk"},   PH_W,  idx, 0, 1200, walk_btn,  0,   1196);
        check_phase({tag, "/flash"},  PH_F,  idx, 0, 600,  flash_btn, 300, 301);
        check_phase({tag, "/clear"},  PH_C,  idx, 0, 100,  '0,        -1,  -1);
        last_idx = idx;
    endtask

    initial begin
        int n;
        #1;
        // 1: idle road stays green
        do_reset();
        check_phase("t1_idle", PH_G, 0, 0, 5000, '0, -1, -1);

        // 2: pulse btn[0] sampled on edge 10 -> yellow on edge 13
        do_reset();
        repeat (9) @(negedge clock);
        btn = 2'b01;
        sb.push_back(0);
        service("t2", 4, '0, '0);

        // 3: press btn[1] on return to green -> full minimum green first
        btn = 2'b10;
        sb.push_back(1);
        service("t3", 1002, '0, '0);

        // 4: both pressed at reset release, then both again
        btn = 2'b11;
        do_reset();
        sb.push_back(0);
        sb.push_back(1);
        service("t4a", 4, '0, '0);
        service("t4b", 1002, '0, '0);
        btn = 2'b11;
        sb.push_back(0);
        sb.push_back(1);
        service("t4c", 1002, '0, '0);
        service("t4d", 1002, '0, '0);

        // 5: hold btn[0] through its own walk, then press it in flash
        btn = '0;
        do_reset();
        btn = 2'b01;
        sb.push_back(0);
        service("t5a", 4, 2'b01, '0);
        check_phase("t5_no_reservice", PH_G, 0, 0, 3000, '0, -1, -1);
        btn = 2'b01;
        sb.push_back(0);
        sb.push_back(0);
        service("t5b", 4, '0, 2'b01);
        service("t5c", 1002, '0, '0);

        // 6: asynchronous reset in the middle of walk
        do_reset();
        btn = 2'b10;
        n   = 0;
        while (walk === '0 && n < 400) begin
            @(negedge clock);
            n++;
            btn = '0;
        end
        vectors++;
        assert (walk === 2'b10) else begin
            miscompares++;
            $error("FAIL t6/reach_walk: observed walk=%b expected 10", walk);
        end
        btn = 2'b01;
        repeat (300) @(negedge clock);
        btn = '0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        assert (obs === exp_out(PH_G, 0, 0)) else begin
            miscompares++;
            $error("FAIL t6/async_reset: observed %h expected %h", obs, exp_out(PH_G, 0, 0));
        end
        do_reset();
        check_phase("t6_pending_lost", PH_G, 0, 0, 1500, '0, -1, -1);
        btn = 2'b10;
        sb.push_back(1);
        service("t6b", 4, '0, '0);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
